exe_seq_ctrl: RTL and testbench

EXE_SEQ_CTRL -- requirements
Module: exe_seq_ctrl

---
 rtl/exe_seq_ctrl_pkg.sv | 18 +
 rtl/retire_counter.sv | 18 +
 rtl/exe_seq_ctrl.sv | 91 +++++++++
 tb/tb_exe_seq_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/exe_seq_ctrl_pkg.sv
// Shared constants for the EXE-stage sequencer: command codes, widths, FSM states.
package exe_seq_ctrl_pkg;

    localparam int EXE_CMD_LEN = 4;
    localparam int WORD_LEN    = 16;
    localparam int CNT_W       = 4;

    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'd0;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'd1;
    localparam logic [EXE_CMD_LEN-1:0] EXE_MUL = 4'd2;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MULTI = 2'd1,
        S_FLUSH = 2'd2
    } seq_state_e;

endpackage

// File: rtl/retire_counter.sv
// Wrapping retirement counter with synchronous clear (clear has priority over enable).
module retire_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/exe_seq_ctrl.sv
// EXE-stage sequencer: stalls for multi-cycle commands, squashes the slot after a
// taken branch, and gates write-enable / branch-taken toward the register file and PC.
module exe_seq_ctrl
    import exe_seq_ctrl_pkg::*;
#(
    parameter int                     MUL_CYCLES = 4,
    parameter logic [EXE_CMD_LEN-1:0] MULTI_CMD  = EXE_MUL
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   Valid_IN,
    input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
    input  logic                   Reg_W_EN_IN,
    input  logic                   BranchTK_IN,
    output logic                   Stall,
    output logic                   Flush,
    output logic                   Reg_W_EN,
    output logic                   BranchTK,
    output logic                   Busy,
    output logic [WORD_LEN-1:0]    Retired
);

    seq_state_e       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             retire;

    always_comb begin
        Stall     = 1'b0;
        Flush     = 1'b0;
        Reg_W_EN  = 1'b0;
        BranchTK  = 1'b0;
        retire    = 1'b0;
        state_nxt = state;
        count_nxt = count;
        if (!nReset) begin
            unique case (state)
                S_RUN: begin
                    if (Valid_IN) begin
                        // A taken branch beats a multi-cycle command in the same slot.
                        if (BranchTK_IN) begin
                            BranchTK  = 1'b1;
                            Flush     = 1'b1;
                            Reg_W_EN  = Reg_W_EN_IN;
                            retire    = 1'b1;
                            state_nxt = S_FLUSH;
                        end else if (EXE_CMD == MULTI_CMD) begin
                            Stall     = 1'b1;
                            count_nxt = CNT_W'(MUL_CYCLES - 2);
                            state_nxt = S_MULTI;
                        end else begin
                            Reg_W_EN  = Reg_W_EN_IN;
                            retire    = 1'b1;
                        end
                    end
                end
                S_MULTI: begin
                    if (count != '0) begin
                        Stall     = 1'b1;
                        count_nxt = count - 1'b1;
                    end else begin
                        Reg_W_EN  = Reg_W_EN_IN;
                        retire    = 1'b1;
                        state_nxt = S_RUN;
                    end
                end
                S_FLUSH: state_nxt = S_RUN;
                default: state_nxt = S_RUN;
            endcase
        end
    end

    assign Busy = !nReset && (state == S_MULTI);

    always_ff @(posedge clk) begin
        if (nReset) begin
            state <= S_RUN;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    retire_counter #(.W(WORD_LEN)) u_retire_counter (
        .clk   (clk),
        .clr   (nReset),
        .en    (retire),
        .count (Retired)
    );

endmodule

// File: tb/tb_exe_seq_ctrl.sv
// Self-checking bench for exe_seq_ctrl: occupancy-based reference model, directed
// scenarios with literal expectations, then a randomized run.
module tb_exe_seq_ctrl;
    import exe_seq_ctrl_pkg::*;

    localparam int MULC = 4;

    logic                   clk = 1'b0;
    logic                   nReset;
    logic                   Valid_IN;
    logic [EXE_CMD_LEN-1:0] EXE_CMD;
    logic                   Reg_W_EN_IN;
    logic                   BranchTK_IN;
    logic                   Stall, Flush, Reg_W_EN, BranchTK, Busy;
    logic [WORD_LEN-1:0]    Retired;

    exe_seq_ctrl #(.MUL_CYCLES(MULC), .MULTI_CMD(EXE_MUL)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .Valid_IN    (Valid_IN),
        .EXE_CMD     (EXE_CMD),
        .Reg_W_EN_IN (Reg_W_EN_IN),
        .BranchTK_IN (BranchTK_IN),
        .Stall       (Stall),
        .Flush       (Flush),
        .Reg_W_EN    (Reg_W_EN),
        .BranchTK    (BranchTK),
        .Busy        (Busy),
        .Retired     (Retired)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pending squash slot, remaining EXE occupancy, retire count.
    bit            m_squash = 1'b0;
    int            m_left   = 0;
    logic [15:0]   m_ret    = '0;
    bit            m_ret_known = 1'b0;
    logic          e_stall, e_flush, e_we, e_br, e_busy;

    int stall_seen, busy_seen, we_seen, flush_seen, br_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_seen();
        stall_seen = 0; busy_seen = 0; we_seen = 0; flush_seen = 0; br_seen = 0;
    endtask

    task automatic step(input logic rst, input logic v, input logic [EXE_CMD_LEN-1:0] cmd,
                        input logic we, input logic br);
        bit ret;
        @(negedge clk);
        nReset = rst; Valid_IN = v; EXE_CMD = cmd; Reg_W_EN_IN = we; BranchTK_IN = br;
        #1;
        e_stall = 0; e_flush = 0; e_we = 0; e_br = 0; e_busy = 0; ret = 0;
        if (rst) begin
        end else if (m_squash) begin
        end else if (m_left > 1) begin
            e_stall = 1; e_busy = 1;
        end else if (m_left == 1) begin
            e_busy = 1; e_we = we; ret = 1;
        end else if (v) begin
            if (br) begin
                e_br = 1; e_flush = 1; e_we = we; ret = 1;
            end else if (cmd == EXE_MUL) begin
                e_stall = 1;
            end else begin
                e_we = we; ret = 1;
            end
        end
        chk("Stall", 32'(Stall), 32'(e_stall));
        chk("Flush", 32'(Flush), 32'(e_flush));
        chk("Reg_W_EN", 32'(Reg_W_EN), 32'(e_we));
        chk("BranchTK", 32'(BranchTK), 32'(e_br));
        chk("Busy", 32'(Busy), 32'(e_busy));
        if (m_ret_known) chk("Retired", 32'(Retired), 32'(m_ret));
        stall_seen += int'(Stall); busy_seen += int'(Busy); we_seen += int'(Reg_W_EN);
        flush_seen += int'(Flush); br_seen += int'(BranchTK);
        @(posedge clk);
        if (rst) begin
            m_squash = 0; m_left = 0; m_ret = '0; m_ret_known = 1;
        end else begin
            if (m_squash) begin
                m_squash = 0;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (v && br) begin
                m_squash = 1;
            end else if (v && cmd == EXE_MUL) begin
                m_left = MULC - 1;
            end
            if (ret) m_ret = m_ret + 16'd1;
        end
        #1;
    endtask

    logic                   h_v, h_we, h_br, h_rst;
    logic [EXE_CMD_LEN-1:0] h_cmd;

    initial begin
        nReset = 1; Valid_IN = 0; EXE_CMD = EXE_ADD; Reg_W_EN_IN = 0; BranchTK_IN = 0;
        clr_seen();

        step(1, 0, EXE_ADD, 0, 0);
        chk("reset_retired", 32'(Retired), 32'd0);

        // Five back-to-back ADDs
        clr_seen();
        repeat (5) step(0, 1, EXE_ADD, 1, 0);
        chk("add_we_cycles", 32'(we_seen), 32'd5);
        chk("add_stall_cycles", 32'(stall_seen), 32'd0);
        chk("add_retired", 32'(Retired), 32'd5);

        // One MUL held for its full occupancy
        clr_seen();
        repeat (MULC) step(0, 1, EXE_MUL, 1, 0);
        chk("mul_stall_cycles", 32'(stall_seen), 32'd3);
        chk("mul_busy_cycles", 32'(busy_seen), 32'd3);
        chk("mul_we_cycles", 32'(we_seen), 32'd1);
        chk("mul_retired", 32'(Retired), 32'd6);

        // Taken branch then squashed slot
        clr_seen();
        step(0, 1, EXE_ADD, 1, 1);
        chk("br_flush", 32'(flush_seen), 32'd1);
        chk("br_branchtk", 32'(br_seen), 32'd1);
        step(0, 1, EXE_ADD, 1, 0);
        chk("br_we_cycles", 32'(we_seen), 32'd1);
        chk("br_retired", 32'(Retired), 32'd7);

        // MUL with branch takes the flush path
        clr_seen();
        step(0, 1, EXE_MUL, 1, 1);
        step(0, 1, EXE_ADD, 1, 0);
        chk("mulbr_busy", 32'(busy_seen), 32'd0);
        chk("mulbr_flush", 32'(flush_seen), 32'd1);
        chk("mulbr_retired", 32'(Retired), 32'd8);

        // Reset in the second MULTI cycle
        step(0, 1, EXE_MUL, 1, 0);
        step(0, 1, EXE_MUL, 1, 0);
        step(1, 1, EXE_MUL, 1, 0);
        chk("rst_mid_retired", 32'(Retired), 32'd0);
        clr_seen();
        step(0, 1, EXE_ADD, 0, 0);
        chk("rst_mid_stall", 32'(stall_seen), 32'd0);
        chk("rst_mid_busy", 32'(busy_seen), 32'd0);
        chk("rst_mid_after", 32'(Retired), 32'd1);

        // Wrap of the retire counter
        step(1, 0, EXE_ADD, 0, 0);
        repeat (65535) step(0, 1, EXE_ADD, 1, 0);
        chk("wrap_preset", 32'(Retired), 32'd65535);
        step(0, 1, EXE_SUB, 1, 0);
        chk("wrap_zero", 32'(Retired), 32'd0);

        // Randomized run; inputs held while the previous cycle stalled
        h_v = 0; h_cmd = EXE_ADD; h_we = 0; h_br = 0;
        for (int i = 0; i < 3000; i++) begin
            h_rst = ($urandom_range(0, 149) == 0);
            if (!e_stall) begin
                h_v   = ($urandom_range(0, 4) != 0);
                h_cmd = ($urandom_range(0, 2) == 0) ? EXE_MUL : EXE_CMD_LEN'($urandom_range(0, 15));
                h_we  = 1'($urandom);
                h_br  = ($urandom_range(0, 5) == 0);
            end
            step(h_rst, h_v, h_cmd, h_we, h_br);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
